alu_operand_ctrl: RTL and testbench
===================================

Name: alu_operand_ctrl

Overview:
- EX-stage operand controller for the pipelined 64-bit CPU.
- Registers the ALU operand-2 select controls (ALUSrc1/ALUSrc2 of the ALU operand-2 mux) and the forwarding selects for both ALU operands.
- Detects load-use hazards and sequences a one-cycle stall with bubble insertion.
- Freezes the pipeline while data memory is busy.
- Sits between ID decode and the ID/EX pipeline register. Pipeline register contents are owned elsewhere; this block tracks only the destinations it needs.

Parameters:
- REG_BITS, 5, register index width.
- ZERO_REG, 31, index of XZR; never forwarded or hazarded.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rn  in  REG_BITS  operand A source register.
- id_rm  in  REG_BITS  operand B source register (Rm or Rt).
- id_uses_rn  in  1  instruction reads Rn.
- id_uses_rm  in  1  instruction reads Rm/Rt.
- id_op_class  in  2  operand class: 00 R-type, 01 D-type (DAddr9), 10 I-type (imm12), 11 other (register).
- id_rd  in  REG_BITS  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  branch taken; squash the ID instruction.
- mem_busy  in  1  data memory not ready; freeze the pipeline.
- ex_alu_src1  out  1  registered; 1 selects DAddr9_EXT.
- ex_alu_src2  out  1  registered; 1 selects imm12_EXT.
- ex_fwd_a  out  2  registered forwarding select for operand A.
- ex_fwd_b  out  2  registered forwarding select for operand B.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX.

Behaviour:
- Reset (async, reset_n=0): all registered outputs 0, all internal EX/MEM valid and reg_write bits 0, FSM to RUN. Release is synchronous to the next clk edge.
- Operand class mapping, registered into EX one cycle after ID:
  - 00 gives src1=0, src2=0.
  - 01 gives src1=1, src2=0.
  - 10 gives src1=0, src2=1.
  - 11 gives src1=0, src2=0.
  - src1=src2=1 is never produced.
- Forwarding select encoding: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- Forwarding rule, computed from ID sources at the ID→EX edge:
  - The instruction currently in EX (becoming MEM) matching gives 10.
  - Otherwise the instruction in MEM (becoming WB) matching gives 01.
  - Otherwise 00.
  - Both matching: EX wins (10).
  - A match requires the tracked valid and reg_write bits set, rd==source, source!=ZERO_REG, and the matching uses_* bit set.
- WB-stage writes need no forwarding: the register file writes mid-cycle.
- Internal tracking: a 2-deep shift of {valid, reg_write, mem_read, rd} for EX and MEM. It advances every edge where the state is not MEM_HOLD.
- Load-use hazard (combinational): EX entry has valid&mem_read&reg_write, its rd!=ZERO_REG, and rd matches a used ID source.
- FSM states:
  - RUN:
    - Load-use hazard: stall=1, bubble=1, go to LOAD_STALL. The EX slot is filled with an invalid entry and EX registered outputs are cleared to 0.
    - mem_busy (takes priority over a hazard): go to MEM_HOLD.
    - Otherwise advance normally.
  - LOAD_STALL: always exactly one cycle. stall=0, bubble=0. The ID instruction is re-evaluated and now forwards 01 from the load. Return to RUN, or to MEM_HOLD if mem_busy.
  - MEM_HOLD: stall=1, bubble=0. Registered outputs and tracking are frozen. Exit to RUN when mem_busy=0; the pending hazard is re-evaluated on exit.
- flush: the ID instruction is treated as invalid for the tracking shift and EX outputs go to 0. Any load-use stall request is cancelled, since flush overrides stall. flush is ignored in MEM_HOLD.
- id_valid=0: treated the same as a flushed slot.
- reset_n asserted mid-stall: immediate return to RUN with all outputs 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - op_class_t enum (R, D, I, OTHER).
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10).
  - ctrl_state_t enum (RUN, LOAD_STALL, MEM_HOLD).
  - ZERO_REG constant.
- Sub-module fwd_compare: a single source-vs-destination match with the XZR guard, instantiated four times.

Test Plan:
- Class map: ADDI (class 10), then LDUR (01), then ADD (00) -> ex_alu_src2/src1 = 1/0, 0/1, 0/0 on successive cycles.
- EX forward: ADD X1,X2,X3 then SUB X4,X1,X5 -> ex_fwd_a=10, ex_fwd_b=00.
- MEM forward and priority:
  - ADD X1 / NOP / ADD X6,X7,X1 -> ex_fwd_b=01.
  - ADD X1 / ADD X1 / ADD X8,X1,X1 -> fwd_a=fwd_b=10.
- Load-use: LDUR X9,[X2,#8] then ADD X10,X9,X3 -> one cycle stall=1, bubble=1, then ex_fwd_a=01. XZR destination -> no stall.
- MEM_HOLD: mem_busy high 3 cycles during a hazard -> stall=1 for 3 cycles with outputs frozen, then the hazard stall, then resume.
- Reset/flush:
  - reset_n low during LOAD_STALL -> outputs 0 and state RUN.
  - flush during a hazard -> bubble=1, no stall, and the squashed instruction is never a forward source.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the EX-stage operand controller: operand classes,
// forwarding selects and controller states.
package cpu_ctrl_pkg;

  localparam int unsigned ZERO_REG = 31;

  typedef enum logic [1:0] {
    OPC_R     = 2'b00,
    OPC_D     = 2'b01,
    OPC_I     = 2'b10,
    OPC_OTHER = 2'b11
  } op_class_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_HOLD   = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/fwd_compare.sv
// One source-vs-destination match. XZR never matches, so it is never
// forwarded and never causes a hazard.
module fwd_compare #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned ZERO_REG = cpu_ctrl_pkg::ZERO_REG
) (
  input  logic [REG_BITS-1:0] src_i,
  input  logic                uses_i,
  input  logic [REG_BITS-1:0] dst_i,
  input  logic                dst_valid_i,
  input  logic                dst_wr_i,
  output logic                match_o
);

  localparam logic [REG_BITS-1:0] XZR = REG_BITS'(ZERO_REG);

  assign match_o = uses_i & dst_valid_i & dst_wr_i &
                   (src_i == dst_i) & (src_i != XZR);

endmodule

// File: rtl/alu_operand_ctrl.sv
// EX-stage operand controller: registers ALU operand selects and forwarding
// selects, and sequences load-use stalls and data-memory freezes.
//
//   state      | meaning
//   RUN        | normal flow; load-use hazard inserts a bubble and stalls
//   LOAD_STALL | one cycle after the bubble; ID re-issues, load now in MEM
//   MEM_HOLD   | data memory busy; outputs and tracking frozen
module alu_operand_ctrl #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned ZERO_REG = cpu_ctrl_pkg::ZERO_REG
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_rm,
  input  logic                id_uses_rn,
  input  logic                id_uses_rm,
  input  logic [1:0]          id_op_class,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  input  logic                mem_busy,
  output logic                ex_alu_src1,
  output logic                ex_alu_src2,
  output logic [1:0]          ex_fwd_a,
  output logic [1:0]          ex_fwd_b,
  output logic                stall,
  output logic                bubble
);

  import cpu_ctrl_pkg::*;

  ctrl_state_t state_q, state_d;

  logic                ex_valid_q, ex_wr_q, ex_ld_q;
  logic [REG_BITS-1:0] ex_rd_q;
  logic                mem_valid_q, mem_wr_q;
  logic [REG_BITS-1:0] mem_rd_q;

  logic     src1_q, src2_q, src1_d, src2_d;
  fwd_sel_t fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  logic m_ex_a, m_ex_b, m_mem_a, m_mem_b;
  logic load_use, advance, squash;

  fwd_compare #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_cmp_ex_a (
    .src_i(id_rn), .uses_i(id_uses_rn), .dst_i(ex_rd_q),
    .dst_valid_i(ex_valid_q), .dst_wr_i(ex_wr_q), .match_o(m_ex_a)
  );
  fwd_compare #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_cmp_ex_b (
    .src_i(id_rm), .uses_i(id_uses_rm), .dst_i(ex_rd_q),
    .dst_valid_i(ex_valid_q), .dst_wr_i(ex_wr_q), .match_o(m_ex_b)
  );
  fwd_compare #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_cmp_mem_a (
    .src_i(id_rn), .uses_i(id_uses_rn), .dst_i(mem_rd_q),
    .dst_valid_i(mem_valid_q), .dst_wr_i(mem_wr_q), .match_o(m_mem_a)
  );
  fwd_compare #(.REG_BITS(REG_BITS), .ZERO_REG(ZERO_REG)) u_cmp_mem_b (
    .src_i(id_rm), .uses_i(id_uses_rm), .dst_i(mem_rd_q),
    .dst_valid_i(mem_valid_q), .dst_wr_i(mem_wr_q), .match_o(m_mem_b)
  );

  assign load_use = id_valid & ex_ld_q & (m_ex_a | m_ex_b);

  always_comb begin
    src1_d = 1'b0;
    src2_d = 1'b0;
    case (op_class_t'(id_op_class))
      OPC_D:   src1_d = 1'b1;
      OPC_I:   src2_d = 1'b1;
      default: ;
    endcase
    // EX/MEM match has priority: it holds the younger value
    fwd_a_d = m_ex_a ? FWD_EXMEM : (m_mem_a ? FWD_MEMWB : FWD_RF);
    fwd_b_d = m_ex_b ? FWD_EXMEM : (m_mem_b ? FWD_MEMWB : FWD_RF);
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    advance = 1'b1;
    squash  = ~id_valid | flush;
    case (state_q)
      LOAD_STALL: begin
        if (mem_busy) begin
          stall   = 1'b1;
          advance = 1'b0;
          state_d = MEM_HOLD;
        end else begin
          state_d = RUN;
        end
      end
      RUN, MEM_HOLD: begin
        // Leaving MEM_HOLD behaves like RUN so a pending hazard is re-checked
        if (mem_busy) begin
          stall   = 1'b1;
          advance = 1'b0;
          state_d = MEM_HOLD;
        end else if (load_use) begin
          bubble = 1'b1;
          squash = 1'b1;
          if (!flush) begin
            stall   = 1'b1;
            state_d = LOAD_STALL;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      ex_valid_q  <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= '0;
      src1_q      <= 1'b0;
      src2_q      <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
    end else begin
      state_q <= state_d;
      if (advance) begin
        mem_valid_q <= ex_valid_q;
        mem_wr_q    <= ex_wr_q;
        mem_rd_q    <= ex_rd_q;
        if (squash) begin
          ex_valid_q <= 1'b0;
          ex_wr_q    <= 1'b0;
          ex_ld_q    <= 1'b0;
          ex_rd_q    <= '0;
          src1_q     <= 1'b0;
          src2_q     <= 1'b0;
          fwd_a_q    <= FWD_RF;
          fwd_b_q    <= FWD_RF;
        end else begin
          ex_valid_q <= 1'b1;
          ex_wr_q    <= id_reg_write;
          ex_ld_q    <= id_mem_read;
          ex_rd_q    <= id_rd;
          src1_q     <= src1_d;
          src2_q     <= src2_d;
          fwd_a_q    <= fwd_a_d;
          fwd_b_q    <= fwd_b_d;
        end
      end
    end
  end

  assign ex_alu_src1 = src1_q;
  assign ex_alu_src2 = src2_q;
  assign ex_fwd_a    = fwd_a_q;
  assign ex_fwd_b    = fwd_b_q;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl: expected EX outputs are queued when an
// instruction is presented in ID and compared after the capturing edge.
module tb_alu_operand_ctrl;

  localparam logic [1:0] RF = 2'b00, MW = 2'b01, EM = 2'b10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_uses_rn, id_uses_rm;
  logic [1:0] id_op_class;
  logic       id_reg_write, id_mem_read;
  logic       flush, mem_busy;
  logic       ex_alu_src1, ex_alu_src2;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic       stall, bubble;

  typedef struct packed {
    logic       s1;
    logic       s2;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_operand_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_op_class(id_op_class), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .mem_busy(mem_busy),
    .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall(stall), .bubble(bubble)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input exp_t e);
    chk({tag, ".src1"},  {1'b0, ex_alu_src1}, {1'b0, e.s1});
    chk({tag, ".src2"},  {1'b0, ex_alu_src2}, {1'b0, e.s2});
    chk({tag, ".fwd_a"}, ex_fwd_a, e.fa);
    chk({tag, ".fwd_b"}, ex_fwd_b, e.fb);
  endtask

  task automatic instr(input logic [1:0] cls, input int rd, input int rn, input int rm,
                       input logic urn, input logic urm, input logic rw, input logic ld);
    id_valid     = 1'b1;
    id_op_class  = cls;
    id_rd        = 5'(rd);
    id_rn        = 5'(rn);
    id_rm        = 5'(rm);
    id_uses_rn   = urn;
    id_uses_rm   = urm;
    id_reg_write = rw;
    id_mem_read  = ld;
  endtask

  task automatic r_ty(input int rd, input int rn, input int rm);
    instr(2'b00, rd, rn, rm, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic i_ty(input int rd, input int rn);
    instr(2'b10, rd, rn, 0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic ldur(input int rt, input int rn);
    instr(2'b01, rt, rn, rt, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic nop();
    instr(2'b00, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
  endtask

  // Called just after a rising edge with ID inputs already applied.
  task automatic cyc(input string tag, input logic e_stall, input logic e_bub,
                     input logic e_s1, input logic e_s2,
                     input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    #3;
    chk({tag, ".stall"},  {1'b0, stall},  {1'b0, e_stall});
    chk({tag, ".bubble"}, {1'b0, bubble}, {1'b0, e_bub});
    e.s1 = e_s1; e.s2 = e_s2; e.fa = e_fa; e.fb = e_fb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      chk_ex(tag, sb_q.pop_front());
    end
  endtask

  initial begin
    exp_t zero_e;
    zero_e   = '0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    mem_busy = 1'b0;
    nop();
    #2;
    chk_ex("reset", zero_e);
    chk("reset.stall",  {1'b0, stall},  2'b00);
    chk("reset.bubble", {1'b0, bubble}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // operand class mapping
    i_ty(20, 21);     cyc("addi",  0, 0, 0, 1, RF, RF);
    ldur(22, 23);     cyc("ldur",  0, 0, 1, 0, RF, RF);
    r_ty(24, 25, 26); cyc("add",   0, 0, 0, 0, RF, RF);

    // EX/MEM forward
    r_ty(1, 2, 3);    cyc("exf0",  0, 0, 0, 0, RF, RF);
    r_ty(4, 1, 5);    cyc("exf1",  0, 0, 0, 0, EM, RF);

    // MEM/WB forward
    r_ty(1, 2, 3);    cyc("mwf0",  0, 0, 0, 0, RF, RF);
    nop();            cyc("mwf1",  0, 0, 0, 0, RF, RF);
    r_ty(6, 7, 1);    cyc("mwf2",  0, 0, 0, 0, RF, MW);

    // both stages match: EX wins
    r_ty(1, 2, 3);    cyc("pri0",  0, 0, 0, 0, RF, RF);
    r_ty(1, 2, 3);    cyc("pri1",  0, 0, 0, 0, RF, RF);
    r_ty(8, 1, 1);    cyc("pri2",  0, 0, 0, 0, EM, EM);

    // XZR destination is never a forward source
    r_ty(31, 2, 3);   cyc("xzr0",  0, 0, 0, 0, RF, RF);
    r_ty(9, 31, 8);   cyc("xzr1",  0, 0, 0, 0, RF, MW);

    // load-use
    ldur(9, 2);       cyc("lu0",   0, 0, 1, 0, RF, RF);
    r_ty(10, 9, 3);   cyc("lu1",   1, 1, 0, 0, RF, RF);
                      cyc("lu2",   0, 0, 0, 0, MW, RF);

    // load to XZR: no stall
    ldur(31, 2);      cyc("luz0",  0, 0, 1, 0, RF, RF);
    r_ty(11, 31, 10); cyc("luz1",  0, 0, 0, 0, RF, MW);

    // memory busy during a hazard
    ldur(12, 2);      cyc("mh0",   0, 0, 1, 0, RF, RF);
    r_ty(13, 12, 3);
    mem_busy = 1'b1;  cyc("mh1",   1, 0, 1, 0, RF, RF);
                      cyc("mh2",   1, 0, 1, 0, RF, RF);
                      cyc("mh3",   1, 0, 1, 0, RF, RF);
    mem_busy = 1'b0;  cyc("mh4",   1, 1, 0, 0, RF, RF);
                      cyc("mh5",   0, 0, 0, 0, MW, RF);
    r_ty(14, 13, 12); cyc("mh6",   0, 0, 0, 0, EM, RF);

    // flush during a hazard
    ldur(15, 2);      cyc("fl0",   0, 0, 1, 0, RF, RF);
    r_ty(16, 15, 14);
    flush = 1'b1;     cyc("fl1",   0, 1, 0, 0, RF, RF);
    flush = 1'b0;
    r_ty(17, 16, 16); cyc("fl2",   0, 0, 0, 0, RF, RF);
    r_ty(18, 16, 17); cyc("fl3",   0, 0, 0, 0, RF, EM);

    // reset asserted during LOAD_STALL
    ldur(19, 2);      cyc("rs0",   0, 0, 1, 0, RF, RF);
    r_ty(20, 19, 3);  cyc("rs1",   1, 1, 0, 0, RF, RF);
    reset_n = 1'b0;
    #2;
    chk_ex("rs_async", zero_e);
    chk("rs_async.stall",  {1'b0, stall},  2'b00);
    chk("rs_async.bubble", {1'b0, bubble}, 2'b00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    r_ty(20, 19, 3);  cyc("rs2",   0, 0, 0, 0, RF, RF);
    r_ty(21, 20, 0);  cyc("rs3",   0, 0, 0, 0, EM, RF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
